timer_tick_service: RTL and testbench

- Hardware consumer of the 1 ms interval-timer interrupt (timer period 50000 clk cycles at 50 MHz).
- After reset, enables the timer interrupt via an Avalon-MM master write to the timer control register. On each timer irq it acknowledges by writing the timer status register, then advances a millisecond/second time base.
- Exposes that time base to the Nios II through its own Avalon-MM slave, plus a per-second interrupt.
- Sole hardware writer of the timer's s1 port; software does not access the timer directly.

---
 rtl/timer_tick_service.sv | 159 +++++++++++++++
 tb/tb_timer_tick_service.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_tick_service.sv
// timer_tick_service: hardware consumer of the 1 ms interval-timer interrupt.
// After reset it enables the timer interrupt with a single master write. On every timer irq it
// acknowledges the timer (clears its status) and advances a millisecond/second time base. That
// time base is readable and writable through a small Avalon-MM slave, and a per-second interrupt
// is raised to the CPU.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   tmr_irq           interrupt from the interval timer
//   tmr_address       timer register address        (master, registered)
//   tmr_chipselect    timer chipselect              (master, registered)
//   tmr_write_n       timer write strobe, low-true  (master, registered)
//   tmr_writedata     timer write data              (master, registered)
//   s_address         slave register address: 0 ms, 1 sec, 2 status/ctrl, 3 event clear
//   s_chipselect      slave select
//   s_read, s_write   slave read / write strobes
//   s_writedata       slave write data
//   s_readdata        slave read data, valid the cycle after the read strobe
//   irq               per-second interrupt = sec_event & sec_irq_en
module timer_tick_service #(
  parameter int unsigned TICKS_PER_SEC = 1000,
  parameter int unsigned SEC_W         = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tmr_irq,
  output logic [2:0]  tmr_address,
  output logic        tmr_chipselect,
  output logic        tmr_write_n,
  output logic [15:0] tmr_writedata,
  input  logic [1:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        irq
);

  localparam int unsigned MsW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [MsW-1:0] MsMax = MsW'(TICKS_PER_SEC - 1);

  localparam logic [1:0] StInitWr = 2'd0;
  localparam logic [1:0] StIdle   = 2'd1;
  localparam logic [1:0] StAckWr  = 2'd2;
  localparam logic [1:0] StHold   = 2'd3;

  logic [1:0]       state;
  logic [MsW-1:0]   ms_cnt, ms_cnt_d;
  logic [SEC_W-1:0] sec_cnt, sec_cnt_d;
  logic             sec_event, sec_event_d;
  logic             sec_irq_en, sec_irq_en_d;
  logic [31:0]      rd_mux;

  logic slv_wr, slv_rd, tick, rollover;

  assign slv_wr   = s_chipselect & s_write;
  assign slv_rd   = s_chipselect & s_read;
  assign tick     = (state == StAckWr);
  assign rollover = tick && (ms_cnt == MsMax);

  // Master outputs are registered from the current state, so each write strobe is visible for
  // exactly the one cycle after the state that issues it, and reset clears them immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= StInitWr;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_address    <= 3'd0;
      tmr_writedata  <= 16'h0000;
    end else begin
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_address    <= 3'd0;
      tmr_writedata  <= 16'h0000;
      case (state)
        StInitWr: begin
          // Control register: enable the timeout interrupt.
          tmr_chipselect <= 1'b1;
          tmr_write_n    <= 1'b0;
          tmr_address    <= 3'd1;
          tmr_writedata  <= 16'h0001;
          state          <= StIdle;
        end
        StIdle: begin
          if (tmr_irq) state <= StAckWr;
        end
        StAckWr: begin
          // Status register write clears the timeout flag.
          tmr_chipselect <= 1'b1;
          tmr_write_n    <= 1'b0;
          state          <= StHold;
        end
        default: begin
          // The timer irq is still high here; ignore it for one cycle.
          state <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    ms_cnt_d     = ms_cnt;
    sec_cnt_d    = sec_cnt;
    sec_event_d  = sec_event;
    sec_irq_en_d = sec_irq_en;

    if (tick) begin
      if (rollover) begin
        ms_cnt_d  = '0;
        sec_cnt_d = sec_cnt + SEC_W'(1);
      end else begin
        ms_cnt_d = ms_cnt + MsW'(1);
      end
    end

    // Slave writes override the tick for the register they target.
    if (slv_wr) begin
      case (s_address)
        2'd0: ms_cnt_d = (s_writedata >= 32'(TICKS_PER_SEC)) ? MsMax : MsW'(s_writedata);
        2'd1: sec_cnt_d = SEC_W'(s_writedata);
        2'd2: sec_irq_en_d = s_writedata[1];
        default: sec_event_d = 1'b0;
      endcase
    end

    // A rollover in the same cycle as a clear keeps the event set.
    if (rollover) sec_event_d = 1'b1;
  end

  always_comb begin
    rd_mux = 32'd0;
    case (s_address)
      2'd0: rd_mux = 32'(ms_cnt);
      2'd1: rd_mux = 32'(sec_cnt);
      2'd2: rd_mux = {30'd0, sec_irq_en, sec_event};
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_cnt     <= '0;
      sec_cnt    <= '0;
      sec_event  <= 1'b0;
      sec_irq_en <= 1'b0;
      s_readdata <= 32'd0;
    end else begin
      ms_cnt     <= ms_cnt_d;
      sec_cnt    <= sec_cnt_d;
      sec_event  <= sec_event_d;
      sec_irq_en <= sec_irq_en_d;
      if (slv_rd) s_readdata <= rd_mux;
    end
  end

  assign irq = sec_event & sec_irq_en;

endmodule

// File: tb/tb_timer_tick_service.sv
module tb_timer_tick_service;

  logic        clk = 1'b0;
  logic        reset;
  logic        tmr_irq;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic [1:0]  s_address;
  logic        s_chipselect;
  logic        s_read;
  logic        s_write;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Expected slave read data, pushed when a read is issued, popped when the data is returned.
  logic [31:0] exp_q[$];

  timer_tick_service #(
    .TICKS_PER_SEC(1000),
    .SEC_W        (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .tmr_irq       (tmr_irq),
    .tmr_address   (tmr_address),
    .tmr_chipselect(tmr_chipselect),
    .tmr_write_n   (tmr_write_n),
    .tmr_writedata (tmr_writedata),
    .s_address     (s_address),
    .s_chipselect  (s_chipselect),
    .s_read        (s_read),
    .s_write       (s_write),
    .s_writedata   (s_writedata),
    .s_readdata    (s_readdata),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  // All tasks start and end 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    s_address    = a;
    s_writedata  = d;
    s_chipselect = 1'b1;
    s_write      = 1'b1;
    step();
    s_chipselect = 1'b0;
    s_write      = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] a, output logic [31:0] d);
    s_address    = a;
    s_chipselect = 1'b1;
    s_read       = 1'b1;
    step();
    s_chipselect = 1'b0;
    s_read       = 1'b0;
    d = s_readdata;
  endtask

  // One timer interrupt pulse; returns right after the ack write became visible.
  task automatic do_tick();
    tmr_irq = 1'b1;
    step();
    tmr_irq = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tmr_irq = 1'b0;
    s_address = 2'd0;
    s_chipselect = 1'b0;
    s_read = 1'b0;
    s_write = 1'b0;
    s_writedata = 32'd0;
    step();
    step();
    checks++;
    if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata, s_readdata, irq}
        !== {1'b0, 1'b1, 3'd0, 16'h0000, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: cs=%b wn=%b addr=%0d data=%h rd=%h irq=%b, expected 0 1 0 0 0 0",
               tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata, s_readdata, irq);
    end
    reset = 1'b0;
    step();
    checks++;
    if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !== {1'b1, 1'b0, 3'd1, 16'h0001})
    begin
      errors++;
      $display("FAIL init_write: cs=%b wn=%b addr=%0d data=%h, expected 1 0 1 0001",
               tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata);
    end
    step();
    checks++;
    if ({tmr_chipselect, tmr_write_n} !== 2'b01) begin
      errors++;
      $display("FAIL init_single_cycle: cs=%b wn=%b, expected 0 1", tmr_chipselect, tmr_write_n);
    end
  endtask

  task automatic test_tick();
    logic [31:0] got, exp;
    do_tick();
    checks++;
    if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !== {1'b1, 1'b0, 3'd0, 16'h0000})
    begin
      errors++;
      $display("FAIL ack_write: cs=%b wn=%b addr=%0d data=%h, expected 1 0 0 0000",
               tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata);
    end
    exp_q.push_back(32'd1);
    do_read(2'd0, got);
    checks++;
    if (tmr_chipselect !== 1'b0) begin
      errors++;
      $display("FAIL ack_single_cycle: cs=%b, expected 0", tmr_chipselect);
    end
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL tick_ms: got %0d, expected %0d", got, exp);
    end
  endtask

  task automatic test_rollover();
    logic [31:0] got, exp;
    do_write(2'd0, 32'd999);
    do_write(2'd1, 32'd41);
    do_write(2'd2, 32'd2);
    do_tick();
    step();
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL rollover_irq: irq=%b, expected 1", irq);
    end
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd42);
    exp_q.push_back(32'd3);
    for (int a = 0; a < 3; a++) begin
      do_read(2'(a), got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rollover_read%0d: got %h, expected %h", a, got, exp);
      end
    end
    do_write(2'd3, 32'd0);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL clear_irq: irq=%b, expected 0", irq);
    end
    exp_q.push_back(32'd2);
    do_read(2'd2, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL clear_status: got %h, expected %h", got, exp);
    end
  endtask

  task automatic test_clear_race();
    logic [31:0] got, exp;
    do_write(2'd0, 32'd999);
    tmr_irq = 1'b1;
    step();
    // FSM is in the ack state now: the clear lands on the rollover edge.
    tmr_irq = 1'b0;
    do_write(2'd3, 32'hDEAD_BEEF);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL race_irq: irq=%b, expected 1", irq);
    end
    exp_q.push_back(32'd43);
    exp_q.push_back(32'd3);
    for (int a = 1; a < 3; a++) begin
      do_read(2'(a), got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL race_read%0d: got %h, expected %h", a, got, exp);
      end
    end
  endtask

  task automatic test_wrap_clamp();
    logic [31:0] got, exp;
    logic [31:0] wr_tab[6] = '{32'd0, 32'd998, 32'd999, 32'd1000, 32'd5000, 32'hFFFF_FFFF};
    do_write(2'd3, 32'd0);
    do_write(2'd0, 32'd999);
    do_write(2'd1, 32'hFFFF_FFFF);
    do_tick();
    step();
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd0);
    for (int a = 0; a < 4; a++) begin
      do_read(2'(a), got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL wrap_read%0d: got %h, expected %h", a, got, exp);
      end
    end
    foreach (wr_tab[i]) begin
      do_write(2'd0, wr_tab[i]);
      exp_q.push_back((wr_tab[i] >= 32'd1000) ? 32'd999 : wr_tab[i]);
      do_read(2'd0, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL clamp_%0d: got %0d, expected %0d", i, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got, exp;
    int strobes = 0;
    do_write(2'd0, 32'd10);
    tmr_irq = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (tmr_chipselect && !tmr_write_n) strobes++;
    end
    tmr_irq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (tmr_chipselect && !tmr_write_n) strobes++;
    end
    checks++;
    if (strobes !== 2) begin
      errors++;
      $display("FAIL stuck_irq_acks: got %0d, expected 2", strobes);
    end
    exp_q.push_back(32'd12);
    do_read(2'd0, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL stuck_irq_ms: got %0d, expected %0d", got, exp);
    end
  endtask

  task automatic test_reset_mid_ack();
    logic [31:0] got, exp;
    do_write(2'd1, 32'd7);
    do_tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({tmr_chipselect, tmr_write_n, irq} !== 3'b010) begin
      errors++;
      $display("FAIL async_reset: cs=%b wn=%b irq=%b, expected 0 1 0",
               tmr_chipselect, tmr_write_n, irq);
    end
    step();
    reset = 1'b0;
    step();
    checks++;
    if ({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !== {1'b1, 1'b0, 3'd1, 16'h0001})
    begin
      errors++;
      $display("FAIL reinit_write: cs=%b wn=%b addr=%0d data=%h, expected 1 0 1 0001",
               tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata);
    end
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    for (int a = 0; a < 3; a++) begin
      do_read(2'(a), got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_counter%0d: got %h, expected %h", a, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_tick();
    test_rollover();
    test_clear_race();
    test_wrap_clamp();
    test_back_to_back();
    test_reset_mid_ack();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
